sseg_scan_ctrl: RTL and testbench
=================================

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed digits; legal range 2..16.
REQ-002 Parameter REFRESH_DIV, default 200_000, clk cycles per digit slot; legal range 2^PWM_BITS or more.
REQ-003 Parameter PWM_BITS, default 4, brightness resolution in bits.
REQ-004 Parameter BLINK_FRAMES, default 32, full scan frames per blink half-period; minimum 1.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 digits  in  4*N_DIGITS  hex nibble per digit; digit i = digits[4i+3:4i]; digit 0 = rightmost.
REQ-008 dp_in  in  N_DIGITS  decimal point request per digit, active-high.
REQ-009 blank  in  N_DIGITS  force digit dark, active-high.
REQ-010 blink  in  N_DIGITS  digit blinks, active-high.
REQ-011 lz_en  in  1  leading-zero suppression enable.
REQ-012 brightness  in  PWM_BITS  duty level; 0 = dark, all-ones = full-on.
REQ-013 seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g.
REQ-014 dp  out  1  decimal point, active-low.
REQ-015 an  out  N_DIGITS  anode enables, active-low, at most one bit low.
REQ-016 frame_tick  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Function
REQ-017 Prescaler counts 0..REFRESH_DIV-1 and wraps; slot tick asserts in the cycle the count equals REFRESH_DIV-1.
REQ-018 Digit index increments on slot tick and wraps N_DIGITS-1 -> 0, including non-power-of-2 N_DIGITS; an index >= N_DIGITS is never reached.
REQ-019 frame_tick pulses in the same cycle as the tick that wraps the index to 0.
REQ-020 Snapshot registers capture digits, dp_in, blank, blink, lz_en on the first clk after rst deasserts and on every frame_tick; display content comes only from the snapshot, so no mid-frame tearing.
REQ-021 brightness is not snapshotted; it takes effect on the next clk.
REQ-022 PWM counter (PWM_BITS wide) increments every clk and clears on slot tick; the digit is lit while pwm_cnt < brightness, and is lit for the whole slot when brightness is all-ones.
REQ-023 Blink phase toggles after every BLINK_FRAMES frame_ticks; blink counter wraps; phase resets to 0 (visible).
REQ-024 A digit is dark when snapshot blank is set, or its blink bit is set and blink phase is 1, or it is leading-zero suppressed, or the PWM condition is false.
REQ-025 Leading-zero suppression with snapshot lz_en=1 blanks digits from N_DIGITS-1 downward while the nibble is 0 and dp_in is 0; it stops at the first non-zero digit; digit 0 is never suppressed.
REQ-026 Hex decode in {g..a} order, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-027 While lit: an = ~(1<<index), seg = decode, dp = ~dp_in(snapshot). While dark: an all-ones, seg=1111111, dp=1.
REQ-028 seg, dp and an are registered and lag the index/PWM state by exactly 1 clk; they have no combinational path from inputs.
REQ-029 Anode change is break-before-make: in the first output cycle of each new slot, an is all-ones.

Reset
REQ-030 On rst: prescaler=0, index=0, pwm_cnt=0, blink counter=0, blink phase=0, snapshot blank=all-ones, other snapshot fields=0.
REQ-031 On rst: an=all-ones, seg=1111111, dp=1, frame_tick=0; all take effect immediately, without waiting for clk.
REQ-032 rst asserted mid-frame aborts the scan; after release, scanning restarts at digit 0 with a fresh snapshot.

Verification (N_DIGITS=4, REFRESH_DIV=4, PWM_BITS=2, BLINK_FRAMES=2)
REQ-033 digits=16'h4321, brightness=3 -> an cycles 1110,1101,1011,0111; seg=1111001/0100100/0110000/0011001; first slot cycle is all-ones; frame_tick every 16 clk.
REQ-034 digits=16'h0070, lz_en=1 -> digits 3 and 2 dark, digit 1 shows 1111000, digit 0 shows 1000000; with dp_in=4'b0100, digit 2 is lit and shows 0 with dp=0.
REQ-035 brightness=1 -> each digit is lit in 1 of 4 slot cycles (minus the break cycle); brightness=0 -> an all-ones for the whole frame.
REQ-036 blink=4'b0001 -> digit 0 dark during frames 2-3 and lit during frames 0-1 and 4-5; other digits are unaffected.
REQ-037 digits changes from 16'h1111 to 16'h2222 mid-frame -> the rest of the frame still shows 1; the next frame shows 2.
REQ-038 rst pulsed at slot 2 -> outputs go dark asynchronously; after release, scanning restarts at an=1110 and frame_tick is first seen 16 clk later.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed seven-segment scanner with PWM dimming, blink and leading-zero blanking
module sseg_scan_ctrl #(
    parameter int N_DIGITS = 8,
    parameter int REFRESH_DIV = 200_000,
    parameter int PWM_BITS = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [N_DIGITS-1:0]   blink,
    input  logic                  lz_en,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_ph;
    logic                  primed;
    logic [4*N_DIGITS-1:0] s_digits;
    logic [N_DIGITS-1:0]   s_dp;
    logic [N_DIGITS-1:0]   s_blank;
    logic [N_DIGITS-1:0]   s_blink;
    logic                  s_lz;
    logic [N_DIGITS-1:0]   sup;
    logic                  run;
    logic                  slot_tick;
    logic                  lit;
    logic [3:0]            nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'ha: hex7 = 7'b0001000;
            4'hb: hex7 = 7'b0000011;
            4'hc: hex7 = 7'b1000110;
            4'hd: hex7 = 7'b0100001;
            4'he: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign slot_tick  = pre == PW'(REFRESH_DIV - 1);
    assign frame_tick = slot_tick && idx == IW'(N_DIGITS - 1);
    assign nib        = s_digits[{idx, 2'b00} +: 4];

    // suppression runs from the leftmost digit and stops at the first non-zero nibble or requested dp
    always_comb begin
        sup = '0;
        run = s_lz;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            run = run && s_digits[4*i +: 4] == 4'd0 && !s_dp[i];
            sup[i] = run;
        end
    end

    // pre == 0 is the break-before-make cycle of every slot
    assign lit = pre != '0 && !s_blank[idx] && !(s_blink[idx] && blink_ph) && !sup[idx] &&
                 (pwm_cnt < brightness || &brightness);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre       <= '0;
            idx       <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            primed    <= 1'b0;
            s_digits  <= '0;
            s_dp      <= '0;
            s_blank   <= '1;
            s_blink   <= '0;
            s_lz      <= 1'b0;
            seg       <= '1;
            dp        <= 1'b1;
            an        <= '1;
        end else begin
            pre     <= slot_tick ? '0 : pre + 1'b1;
            pwm_cnt <= slot_tick ? '0 : pwm_cnt + 1'b1;
            if (slot_tick)
                idx <= frame_tick ? '0 : idx + 1'b1;
            if (frame_tick) begin
                blink_cnt <= blink_cnt == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
                if (blink_cnt == BW'(BLINK_FRAMES - 1))
                    blink_ph <= !blink_ph;
            end
            if (!primed || frame_tick) begin
                primed   <= 1'b1;
                s_digits <= digits;
                s_dp     <= dp_in;
                s_blank  <= blank;
                s_blink  <= blink;
                s_lz     <= lz_en;
            end
            an  <= lit ? ~(N_DIGITS'(1) << idx) : '1;
            seg <= lit ? hex7(nib) : '1;
            dp  <= lit ? !s_dp[idx] : 1'b1;
        end
    end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: directed and random scan checks against a cycle-count based display model
module tb_sseg_scan_ctrl;
    localparam int N = 4;
    localparam int DIV = 4;
    localparam int PB = 2;
    localparam int BF = 2;
    localparam int FR = N * DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4*N-1:0] digits = '0;
    logic [N-1:0] dp_in = '0;
    logic [N-1:0] blank = '0;
    logic [N-1:0] blink = '0;
    logic lz_en = 1'b0;
    logic [PB-1:0] brightness = '0;
    logic [6:0] seg;
    logic dp;
    logic [N-1:0] an;
    logic frame_tick;

    int checks = 0;
    int errors = 0;
    int c = 0;
    logic [4*N-1:0] s_dig;
    logic [N-1:0] s_dp, s_blank, s_blink;
    logic s_lz;
    logic [6:0] dec [16];

    sseg_scan_ctrl #(
        .N_DIGITS(N),
        .REFRESH_DIV(DIV),
        .PWM_BITS(PB),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .digits(digits),
        .dp_in(dp_in),
        .blank(blank),
        .blink(blink),
        .lz_en(lz_en),
        .brightness(brightness),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at c=%0d: got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    // a digit is suppressed when every digit from it up to the leftmost is a bare zero
    function automatic bit lz_sup(input int i);
        if (!s_lz || i == 0)
            return 1'b0;
        for (int j = i; j < N; j++)
            if (s_dig[4*j +: 4] != 4'd0 || s_dp[j])
                return 1'b0;
        return 1'b1;
    endfunction

    // c counts clk edges since reset release; slot, digit and frame follow by division
    task automatic step();
        int pre, idx, fr;
        bit lit;
        logic [N-1:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        pre = c % DIV;
        idx = (c / DIV) % N;
        fr = c / FR;
        lit = pre != 0 && !s_blank[idx] && !(s_blink[idx] && (fr / BF) % 2 == 1) && !lz_sup(idx) &&
              (pre % (1 << PB) < int'(brightness) || int'(brightness) == (1 << PB) - 1);
        e_an = '1;
        if (lit)
            e_an[idx] = 1'b0;
        e_seg = lit ? dec[s_dig[4*idx +: 4]] : 7'h7f;
        e_dp = lit ? !s_dp[idx] : 1'b1;
        if (c + 1 == 1 || (c + 1) % FR == 0) begin
            s_dig = digits;
            s_dp = dp_in;
            s_blank = blank;
            s_blink = blink;
            s_lz = lz_en;
        end
        @(posedge clk);
        c++;
        @(negedge clk);
        check("an", 8'(an), 8'(e_an));
        check("seg", 8'(seg), 8'(e_seg));
        check("dp", 8'(dp), 8'(e_dp));
        check("frame_tick", 8'(frame_tick), 8'((c % FR) == FR - 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_an", 8'(an), 8'h0f);
        check("rst_seg", 8'(seg), 8'h7f);
        check("rst_dp", 8'(dp), 8'h01);
        check("rst_frame_tick", 8'(frame_tick), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c = 0;
        s_dig = '0;
        s_dp = '0;
        s_blank = '1;
        s_blink = '0;
        s_lz = 1'b0;
    endtask

    initial begin
        dec = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        #2;
        digits = 16'h4321;
        brightness = 2'd3;
        do_reset();
        repeat (2 * FR) step();
        digits = 16'h0070;
        lz_en = 1'b1;
        repeat (2 * FR) step();
        dp_in = 4'b0100;
        repeat (2 * FR) step();
        dp_in = '0;
        lz_en = 1'b0;
        digits = 16'h4321;
        brightness = 2'd1;
        repeat (2 * FR) step();
        brightness = 2'd0;
        repeat (FR) step();
        brightness = 2'd2;
        repeat (FR) step();
        brightness = 2'd3;
        blink = 4'b0001;
        do_reset();
        repeat (6 * FR) step();
        blink = '0;
        digits = 16'h1111;
        repeat (FR + 6) step();
        digits = 16'h2222;
        repeat (FR + 10) step();
        repeat (600) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < N; k++)
                    digits[4*k +: 4] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
                dp_in = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0;
                blank = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
                blink = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0;
                lz_en = 1'($urandom);
            end
            if ($urandom_range(0, 3) == 0)
                brightness = 2'($urandom);
            step();
        end
        digits = 16'h8a5c;
        dp_in = '0;
        blank = '0;
        blink = '0;
        lz_en = 1'b0;
        brightness = 2'd3;
        repeat (FR) step();
        while (c % FR != 10)
            step();
        check("pre_rst_lit", 8'(an), 8'h0b);
        do_reset();
        repeat (2 * FR) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
